// File: rtl/enc_pkg.sv
// Shared types and helpers for the two-requester iterative round scheduler.
// Holds the 2-bit lane substitution table, the FSM state encoding and the default round count.
package enc_pkg;

  localparam int ROUNDS_DEFAULT = 3;

  // Lane substitution indexed by the 2-bit input lane value.
  localparam logic [1:0] SBOX2 [4] = '{2'b00, 2'b10, 2'b01, 2'b10};

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } fsm_e;

  function automatic logic [1:0] lane_sub(input logic [1:0] lane);
    return SBOX2[lane];
  endfunction

endpackage

// File: rtl/enc_round_scheduler_if.sv
// Requester and ciphertext channels of the round scheduler.
// The scheduler is the slave side; the sources and the consumer together form the master side.
interface enc_round_scheduler_if #(
  parameter int N = 8
);
  logic         req0_valid;
  logic         req0_ready;
  logic [N-1:0] req0_data;
  logic [N-1:0] req0_key;
  logic         req1_valid;
  logic         req1_ready;
  logic [N-1:0] req1_data;
  logic [N-1:0] req1_key;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_id;

  modport master (
    output req0_valid, req0_data, req0_key,
    output req1_valid, req1_data, req1_key,
    output out_ready,
    input  req0_ready, req1_ready, out_valid, out_data, out_id
  );

  modport slave (
    input  req0_valid, req0_data, req0_key,
    input  req1_valid, req1_data, req1_key,
    input  out_ready,
    output req0_ready, req1_ready, out_valid, out_data, out_id
  );
endinterface

// File: rtl/enc_round.sv
// One combinational encryption round: lane substitution, rotate left by one, then
// XOR with the key mixed with the zero-extended round index.
module enc_round
  import enc_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] state_i,
  input  logic [N-1:0] key_i,
  input  logic [N-1:0] rnd_i,
  output logic [N-1:0] next_state_o
);

  logic [N-1:0] sub;
  logic [N-1:0] rot;

  always_comb begin
    sub = '0;
    for (int i = 0; i < N; i += 2) begin
      sub[i+:2] = lane_sub(state_i[i+:2]);
    end
  end

  assign rot          = {sub[N-2:0], sub[N-1]};
  assign next_state_o = rot ^ key_i ^ rnd_i;

endmodule

// File: rtl/enc_round_scheduler.sv
// Shares one iterative round engine between two requesters with round-robin arbitration;
// the finished block is presented on a registered valid/ready channel tagged with its owner.
module enc_round_scheduler
  import enc_pkg::*;
#(
  parameter int N      = 8,
  parameter int ROUNDS = ROUNDS_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  enc_round_scheduler_if.slave  bus
);

  fsm_e         fsm_q,  fsm_d;
  logic [N-1:0] blk_q,  blk_d;
  logic [N-1:0] key_q,  key_d;
  logic [N-1:0] rnd_q,  rnd_d;
  logic         id_q,   id_d;
  logic         last_q, last_d;
  logic [N-1:0] round_out;
  logic         grant0, grant1;
  logic         rdy0,   rdy1;

  enc_round #(.N(N)) u_round (
    .state_i      (blk_q),
    .key_i        (key_q),
    .rnd_i        (rnd_q),
    .next_state_o (round_out)
  );

  // On contention the requester that did not win last time is served.
  assign grant0 = bus.req0_valid & (~bus.req1_valid | last_q);
  assign grant1 = bus.req1_valid & (~bus.req0_valid | ~last_q);

  // NOTE: every signal written here gets its hold value first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    fsm_d  = fsm_q;
    blk_d  = blk_q;
    key_d  = key_q;
    rnd_d  = rnd_q;
    id_d   = id_q;
    last_d = last_q;
    rdy0   = 1'b0;
    rdy1   = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        rdy0 = grant0;
        rdy1 = grant1;
        if (grant0) begin
          blk_d  = bus.req0_data;
          key_d  = bus.req0_key;
          id_d   = 1'b0;
          last_d = 1'b0;
          rnd_d  = '0;
          fsm_d  = ROUND;
        end else if (grant1) begin
          blk_d  = bus.req1_data;
          key_d  = bus.req1_key;
          id_d   = 1'b1;
          last_d = 1'b1;
          rnd_d  = '0;
          fsm_d  = ROUND;
        end
      end
      ROUND: begin
        blk_d = round_out;
        rnd_d = rnd_q + N'(1);
        if (rnd_q == N'(ROUNDS - 1)) fsm_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values of its neighbours.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q  <= IDLE;
      blk_q  <= '0;
      key_q  <= '0;
      rnd_q  <= '0;
      id_q   <= 1'b0;
      last_q <= 1'b1;
    end else begin
      fsm_q  <= fsm_d;
      blk_q  <= blk_d;
      key_q  <= key_d;
      rnd_q  <= rnd_d;
      id_q   <= id_d;
      last_q <= last_d;
    end
  end

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.out_valid  = (fsm_q == DONE);
  assign bus.out_data   = blk_q;
  assign bus.out_id     = id_q;

endmodule

// File: tb/tb_enc_round_scheduler.sv
// Self-checking bench for enc_round_scheduler: directed scenarios followed by random traffic,
// all compared cycle by cycle against a transaction-level reference model.
module tb_enc_round_scheduler;
  localparam int N      = 8;
  localparam int ROUNDS = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  enc_round_scheduler_if #(.N(N)) bus ();

  enc_round_scheduler #(.N(N), .ROUNDS(ROUNDS)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a block owned by the engine, cycles elapsed since its acceptance.
  bit           m_busy = 1'b0;
  int           m_cnt  = 0;
  bit           m_last = 1'b1;
  logic [N-1:0] m_data = '0;
  logic         m_id   = 1'b0;

  logic         s_valid, s_r0, s_r1, s_id;
  logic [N-1:0] s_data;
  int           grants[$];

  function automatic logic [N-1:0] ref_encrypt(input logic [N-1:0] d, input logic [N-1:0] k);
    int s = int'(d);
    for (int r = 0; r < ROUNDS; r++) begin
      int t = 0;
      for (int l = 0; l < N / 2; l++) begin
        int v = (s >> (2 * l)) & 3;
        int m = (v == 0) ? 0 : (v == 1) ? 2 : (v == 2) ? 1 : 2;
        t = t | (m << (2 * l));
      end
      s = ((t << 1) | (t >> (N - 1))) & ((1 << N) - 1);
      s = s ^ int'(k) ^ r;
    end
    return N'(s);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs on the falling edge, sample and compare 1ns later,
  // then advance the model to what the next rising edge does.
  task automatic cycle(input logic v0, input logic [N-1:0] d0, input logic [N-1:0] k0,
                       input logic v1, input logic [N-1:0] d1, input logic [N-1:0] k1,
                       input logic ordy, input logic rst_v);
    bit e_r0, e_r1, e_v;
    @(negedge clk);
    bus.req0_valid = v0; bus.req0_data = d0; bus.req0_key = k0;
    bus.req1_valid = v1; bus.req1_data = d1; bus.req1_key = k1;
    bus.out_ready  = ordy;
    rst            = rst_v;
    #1;
    s_valid = bus.out_valid; s_data = bus.out_data; s_id = bus.out_id;
    s_r0 = bus.req0_ready;   s_r1 = bus.req1_ready;
    if (s_r0) grants.push_back(0);
    if (s_r1) grants.push_back(1);
    e_r0 = !m_busy && v0 && (!v1 || m_last);
    e_r1 = !m_busy && v1 && (!v0 || !m_last);
    e_v  = m_busy && (m_cnt > ROUNDS);
    check("req0_ready", s_r0, e_r0);
    check("req1_ready", s_r1, e_r1);
    check("out_valid", s_valid, e_v);
    if (e_v) begin
      check("out_data", s_data, m_data);
      check("out_id", s_id, m_id);
    end
    if (rst_v) begin
      m_busy = 1'b0; m_cnt = 0; m_last = 1'b1;
    end else if (e_r0 || e_r1) begin
      m_busy = 1'b1; m_cnt = 1;
      m_id   = e_r1;
      m_last = e_r1;
      m_data = e_r1 ? ref_encrypt(d1, k1) : ref_encrypt(d0, k0);
    end else if (m_busy) begin
      if (e_v && ordy) m_busy = 1'b0;
      else m_cnt++;
    end
  endtask

  // Idle inputs with out_ready high until out_valid shows; lat is 0 if it never does.
  task automatic wait_out(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
      if (s_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  function automatic logic [N-1:0] rnd8();
    return N'($urandom);
  endfunction

  initial begin
    int lat;
    int held;
    bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_key = '0;
    bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_key = '0;
    bus.out_ready  = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_id", bus.out_id, 0);
    check("rst_req0_ready", bus.req0_ready, 0);
    check("rst_req1_ready", bus.req1_ready, 0);

    // Single requester 0, all-zero block.
    cycle(1'b1, 8'h00, 8'h00, 1'b0, '0, '0, 1'b1, 1'b0);
    check("t1_grant0", s_r0, 1);
    wait_out(lat);
    check("t1_latency", lat, 4);
    check("t1_data", s_data, 8'h06);
    check("t1_id", s_id, 0);
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
    check("t1_bubble", s_valid, 0);

    // Single requester 1, all-ones block.
    cycle(1'b0, '0, '0, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0);
    check("t2_grant1", s_r1, 1);
    wait_out(lat);
    check("t2_latency", lat, 4);
    check("t2_data", s_data, 8'h53);
    check("t2_id", s_id, 1);

    // Both requesters always valid from reset: grants must alternate starting with 0.
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b1);
    grants.delete();
    repeat (4 * (ROUNDS + 2)) cycle(1'b1, rnd8(), rnd8(), 1'b1, rnd8(), rnd8(), 1'b1, 1'b0);
    check("t3_grant_count", grants.size(), 4);
    foreach (grants[i]) check($sformatf("t3_grant%0d", i), grants[i], i % 2);

    // Backpressure: out_ready low while requesters keep asking.
    held = 0;
    repeat (ROUNDS + 14) begin
      cycle(1'b1, rnd8(), rnd8(), 1'b1, rnd8(), rnd8(), 1'b0, 1'b0);
      if (s_valid) held++;
    end
    check("t4_held_at_least_10", held >= 10, 1);
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
    check("t4_release_valid", s_valid, 1);
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
    check("t4_after_release", s_valid, 0);

    // Reset in ROUND after a req0 grant: req0 must still win the next contention.
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b1);
    cycle(1'b1, rnd8(), rnd8(), 1'b0, '0, '0, 1'b1, 1'b0);
    check("t5_first_grant0", s_r0, 1);
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b1);
    cycle(1'b1, 8'h00, 8'h00, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0);
    check("t5_after_rst_valid", s_valid, 0);
    check("t5_req0_wins", s_r0, 1);
    wait_out(lat);
    check("t5_id", s_id, 0);
    check("t5_data", s_data, 8'h06);

    // Requester inputs change during ROUND; latched block must be unaffected.
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b1);
    cycle(1'b1, 8'h00, 8'h00, 1'b0, '0, '0, 1'b1, 1'b0);
    repeat (ROUNDS) cycle(1'b1, rnd8() | 8'h01, rnd8(), 1'b0, '0, '0, 1'b1, 1'b0);
    wait_out(lat);
    check("t6_data", s_data, 8'h06);
    check("t6_id", s_id, 0);

    // Random traffic with random backpressure.
    repeat (400) begin
      cycle(1'($urandom_range(0, 1)), rnd8(), rnd8(), 1'($urandom_range(0, 1)), rnd8(), rnd8(),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
